// File: rtl/ip4_sm_bk_arb.sv
// ip4_sm_bk_arb: single-port bank arbiter in front of an ip4_sm_bk macro.
// Requester 0 (DSE pipeline) has priority over the secondary requesters
// (1..NUM_REQ-1). A secondary requester that has waited MAX_WAIT cycles
// wins over requester 0. Otherwise the secondaries share the bank round-robin.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_vld/wen/adr/dat packed per-requester request (requester i at slot i)
//   req_rdy             one-hot-or-zero grant (combinational)
//   rsp_vld/id/dat      read response, one cycle after a read grant
//   bk_wen/adr/dat      bank command (combinational from the winner)
//   bk_q                bank read data (1-cycle latency)
module ip4_sm_bk_arb #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ-1:0]         req_wen,
  input  logic [NUM_REQ*AW-1:0]      req_adr,
  input  logic [NUM_REQ*DW-1:0]      req_dat,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic                       rsp_vld,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DW-1:0]              rsp_dat,
  output logic                       bk_wen,
  output logic [AW-1:0]              bk_adr,
  output logic [DW-1:0]              bk_dat,
  input  logic [DW-1:0]              bk_q
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  logic [NUM_REQ-1:1][CW-1:0] wait_cnt;
  logic [IW-1:0]              rr_ptr;
  logic                       rsp_vld_q;

  logic [NUM_REQ-1:0] starve;
  logic [NUM_REQ-1:0] sec_vld;
  logic [NUM_REQ-1:0] above_ptr;
  logic [NUM_REQ-1:0] rr_hi;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      win_id;
  logic               sec_gnt;
  logic               rd_gnt;

  // Isolate the lowest set bit (lowest index wins).
  function automatic logic [NUM_REQ-1:0] low_bit(input logic [NUM_REQ-1:0] v);
    return v & (~v + NUM_REQ'(1));
  endfunction

  // Candidate vectors: starved secondaries, valid secondaries, secondaries after the pointer.
  always_comb begin
    starve    = '0;
    sec_vld   = '0;
    above_ptr = '0;
    for (int i = 1; i < NUM_REQ; i++) begin
      starve[i]    = req_vld[i] && (wait_cnt[i] == CW'(MAX_WAIT));
      sec_vld[i]   = req_vld[i];
      above_ptr[i] = (IW'(i) > rr_ptr);
    end
    rr_hi = sec_vld & above_ptr;
  end

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt = '0;
    if (!rst_n)           gnt = '0;
    else if (|starve)     gnt = low_bit(starve);
    else if (req_vld[0])  gnt = NUM_REQ'(1);
    else if (|rr_hi)      gnt = low_bit(rr_hi);
    else                  gnt = low_bit(sec_vld);
  end

  // Winner index and bank command mux.
  always_comb begin
    win_id = '0;
    bk_wen = 1'b0;
    bk_adr = '0;
    bk_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_id = IW'(i);
        bk_wen = req_wen[i];
        bk_adr = req_adr[i*AW +: AW];
        bk_dat = req_dat[i*DW +: DW];
      end
    end
    sec_gnt = |gnt[NUM_REQ-1:1];
    rd_gnt  = (|gnt) && !bk_wen;
  end

  assign req_rdy = gnt;
  // Gated so a read granted just before reset never shows a response during reset.
  assign rsp_vld = rsp_vld_q && rst_n;
  assign rsp_dat = bk_q;

  // Wait counters, round-robin pointer and response tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      rr_ptr    <= IW'(NUM_REQ - 1);
      rsp_vld_q <= 1'b0;
      rsp_id    <= '0;
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (gnt[i] || !req_vld[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CW'(MAX_WAIT)) begin
          wait_cnt[i] <= wait_cnt[i] + CW'(1);
        end
      end
      if (sec_gnt) rr_ptr <= win_id;
      rsp_vld_q <= rd_gnt;
      if (rd_gnt) rsp_id <= win_id;
    end
  end

endmodule

// File: tb/tb_ip4_sm_bk_arb.sv
// Testbench for ip4_sm_bk_arb: directed scenarios plus random traffic,
// checked against a rule-level reference model and a bank memory model.
module tb_ip4_sm_bk_arb;
  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int MW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_vld;
  logic [NR-1:0]     req_wen;
  logic [NR*AW-1:0]  req_adr;
  logic [NR*DW-1:0]  req_dat;
  logic [NR-1:0]     req_rdy;
  logic              rsp_vld;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_dat;
  logic              bk_wen;
  logic [AW-1:0]     bk_adr;
  logic [DW-1:0]     bk_dat;
  logic [DW-1:0]     bk_q;

  ip4_sm_bk_arb #(.NUM_REQ(NR), .AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_wen(req_wen), .req_adr(req_adr), .req_dat(req_dat),
    .req_rdy(req_rdy),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_dat(rsp_dat),
    .bk_wen(bk_wen), .bk_adr(bk_adr), .bk_dat(bk_dat), .bk_q(bk_q)
  );

  always #5 clk = ~clk;

  // Bank macro model: write or registered read every cycle.
  logic [DW-1:0] bank_mem [1024];
  always @(posedge clk) begin
    if (bk_wen) bank_mem[bk_adr] <= bk_dat;
    else        bk_q <= bank_mem[bk_adr];
  end

  // Reference model state.
  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_wait [NR];
  int            m_ptr;
  bit            m_wen [NR];
  logic [AW-1:0] m_adr [NR];
  logic [DW-1:0] m_dat [NR];
  logic [DW-1:0] ref_mem [1024];
  bit            prev_rd;
  int            prev_id;
  logic [DW-1:0] prev_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_wen[i] = w;
    m_adr[i] = a;
    m_dat[i] = d;
  endtask

  // Winner from the arbitration rules: starved secondary, then requester 0, then round-robin.
  function automatic int ref_winner(input bit r, input logic [NR-1:0] v);
    if (!r) return -1;
    for (int i = 1; i < NR; i++) if (v[i] && m_wait[i] == MW) return i;
    if (v[0]) return 0;
    for (int k = 1; k < NR; k++) begin
      int c;
      c = ((m_ptr - 1 + k) % (NR - 1)) + 1;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // One clock cycle: drive at negedge, check after settling, advance the model.
  task automatic cyc(input bit r, input logic [NR-1:0] v);
    int w;
    bit e_rv;
    logic [NR-1:0] e_rdy;
    @(negedge clk);
    rst_n   = r;
    req_vld = v;
    for (int i = 0; i < NR; i++) begin
      req_wen[i]             = m_wen[i];
      req_adr[i*AW +: AW]    = m_adr[i];
      req_dat[i*DW +: DW]    = m_dat[i];
    end
    #1;
    w     = ref_winner(r, v);
    e_rdy = (w >= 0) ? NR'(1 << w) : '0;
    chk("req_rdy", 64'(req_rdy), 64'(e_rdy));
    chk("bk_wen", 64'(bk_wen), (w >= 0) ? 64'(m_wen[w]) : 64'(0));
    if (w >= 0) begin
      chk("bk_adr", 64'(bk_adr), 64'(m_adr[w]));
      if (m_wen[w]) chk("bk_dat", 64'(bk_dat), 64'(m_dat[w]));
    end else begin
      chk("bk_adr_idle", 64'(bk_adr), 64'(0));
      chk("bk_dat_idle", 64'(bk_dat), 64'(0));
    end
    e_rv = r && prev_rd;
    chk("rsp_vld", 64'(rsp_vld), 64'(e_rv));
    if (e_rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(prev_id));
      chk("rsp_dat", 64'(rsp_dat), 64'(prev_dat));
    end
    prev_rd = (w >= 0) && !m_wen[w];
    if (prev_rd) begin
      prev_id  = w;
      prev_dat = ref_mem[m_adr[w]];
    end
    if (w >= 0 && m_wen[w]) ref_mem[m_adr[w]] = m_dat[w];
    if (!r) begin
      for (int i = 0; i < NR; i++) m_wait[i] = 0;
      m_ptr = NR - 1;
    end else begin
      for (int i = 1; i < NR; i++) begin
        if (i == w || !v[i]) m_wait[i] = 0;
        else if (m_wait[i] < MW) m_wait[i]++;
      end
      if (w >= 1) m_ptr = w;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = '0;
    req_wen = '0;
    req_adr = '0;
    req_dat = '0;
    prev_rd = 1'b0;
    prev_id = 0;
    prev_dat = '0;
    m_ptr   = NR - 1;
    for (int i = 0; i < 1024; i++) begin
      bank_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    for (int i = 0; i < NR; i++) begin
      m_wait[i] = 0;
      set_req(i, 1'b1, AW'(16 + i), DW'(32'h1000 + i));
    end

    // Reset with all requesters writing: no grant, then requester 0 first.
    cyc(1'b0, 4'b1111);
    cyc(1'b0, 4'b1111);
    cyc(1'b1, 4'b1111);
    cyc(1'b1, 4'b0000);

    // Write then read the same address from requester 1.
    set_req(1, 1'b1, AW'(5), 32'hA5A5_A5A5);
    cyc(1'b1, 4'b0010);
    set_req(1, 1'b0, AW'(5), 32'h0);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0000);

    // Starvation of requester 2 behind continuous requester 0.
    set_req(0, 1'b0, AW'(16), 32'h0);
    set_req(2, 1'b0, AW'(18), 32'h0);
    repeat (12) cyc(1'b1, 4'b0101);
    cyc(1'b1, 4'b0000);

    // Round-robin among secondaries, back-to-back reads.
    set_req(1, 1'b0, AW'(17), 32'h0);
    set_req(3, 1'b0, AW'(19), 32'h0);
    repeat (7) cyc(1'b1, 4'b1110);
    cyc(1'b1, 4'b0000);

    // Simultaneous starvation of requesters 1 and 3.
    repeat (13) cyc(1'b1, 4'b1011);
    cyc(1'b1, 4'b0000);

    // Read granted immediately before reset is dropped.
    set_req(2, 1'b0, AW'(5), 32'h0);
    cyc(1'b1, 4'b0100);
    cyc(1'b0, 4'b0100);
    cyc(1'b1, 4'b0000);
    cyc(1'b1, 4'b0000);

    // Random traffic on a small address window to exercise read-after-write.
    for (int n = 0; n < 400; n++) begin
      logic [NR-1:0] v;
      bit r;
      v = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) v[0] = 1'b1;
      r = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < NR; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      cyc(r, v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
